// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types, funct3 encodings and access checks for mem_responder
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Flags misaligned halves/words and any funct3 that is not a legal load/store size.
  function automatic logic access_err(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic err;
    err = 1'b1;
    case (f3)
      F3_B:    err = 1'b0;
      F3_H:    err = a[0];
      F3_W:    err = (a != 2'b00);
      F3_BU:   err = we;
      F3_HU:   err = we | a[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - little-endian byte/half lane select with sign or zero extension
module load_align
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [31:0]           word,
  input  logic [1:0]            addr_lo,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Bring the addressed lane down to bit 0, then extend according to funct3.
  always_comb begin
    shifted = word >> {addr_lo, 3'b000};
    byte_v  = shifted[7:0];
    half_v  = shifted[15:0];
    rdata   = '0;
    case (funct3)
      F3_B:    rdata = DATA_WIDTH'($signed(byte_v));
      F3_H:    rdata = DATA_WIDTH'($signed(half_v));
      F3_W:    rdata = DATA_WIDTH'(word);
      F3_BU:   rdata = DATA_WIDTH'(byte_v);
      F3_HU:   rdata = DATA_WIDTH'(half_v);
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - byte-addressed memory slave with wait states and one outstanding request
module mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [2:0]            req_funct3,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int         MEM_BYTES = 2 ** ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT  = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic [7:0]            mem [MEM_BYTES];

  logic                  acc_we;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [2:0]            acc_funct3;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic                  acc_err;
  logic [31:0]           rd_word;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [3:0]            be;
  logic [31:0]           wlanes;
  logic                  enter_resp;
  logic                  mem_we;

  // With zero wait states the access happens on the accept edge, so operands come straight from the request.
  always_comb begin
    if (state_q == IDLE) begin
      acc_we     = req_we;
      acc_addr   = req_addr;
      acc_funct3 = req_funct3;
      acc_wdata  = req_wdata;
    end else begin
      acc_we     = we_q;
      acc_addr   = addr_q;
      acc_funct3 = funct3_q;
      acc_wdata  = wdata_q;
    end
    acc_err = access_err(acc_we, acc_funct3, acc_addr[1:0]);
  end

  // Read the aligned word containing the access; legal accesses never cross it.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < 4; i++) begin
      rd_word[8*i +: 8] = mem[{acc_addr[ADDR_WIDTH-1:2], 2'(i)}];
    end
  end

  // Store byte enables and lane-replicated write data.
  always_comb begin
    be     = 4'b0000;
    wlanes = '0;
    case (acc_funct3)
      F3_B: begin
        be     = 4'b0001 << acc_addr[1:0];
        wlanes = {4{acc_wdata[7:0]}};
      end
      F3_H: begin
        be     = 4'b0011 << {acc_addr[1], 1'b0};
        wlanes = {2{acc_wdata[15:0]}};
      end
      F3_W: begin
        be     = 4'b1111;
        wlanes = acc_wdata[31:0];
      end
      default: begin
        be     = 4'b0000;
        wlanes = '0;
      end
    endcase
  end

  load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
    .word    (rd_word),
    .addr_lo (acc_addr[1:0]),
    .funct3  (acc_funct3),
    .rdata   (ld_data)
  );

  // Next-state, request latching and response capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    funct3_d    = funct3_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    req_ready   = 1'b0;
    enter_resp  = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d     = req_we;
          addr_d   = req_addr;
          funct3_d = req_funct3;
          wdata_d  = req_wdata;
          if (WAIT_CYCLES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (enter_resp) begin
      rsp_rdata_d = (!acc_we && !acc_err) ? ld_data : '0;
      rsp_err_d   = acc_err;
    end
  end

  assign mem_we    = enter_resp && acc_we && !acc_err;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // State and latched-request registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      funct3_q    <= 3'b000;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      funct3_q    <= funct3_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Byte-enabled memory write; contents survive reset, and reset suppresses a pending write.
  always_ff @(posedge CLK) begin
    if (!RST && mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[{acc_addr[ADDR_WIDTH-1:2], 2'(i)}] <= wlanes[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder (2 and 0 wait states)
module tb_mem_responder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [8:0]  req_addr   [2];
  logic [2:0]  req_funct3 [2];
  logic [31:0] req_wdata  [2];
  logic        rsp_valid  [2];
  logic        rsp_ready  [2];
  logic [31:0] rsp_rdata  [2];
  logic        rsp_err    [2];

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .WAIT_CYCLES(2)) dut_w2 (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_funct3(req_funct3[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .WAIT_CYCLES(0)) dut_w0 (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_funct3(req_funct3[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request with rsp_ready held high; lat counts negedges after the accept edge until rsp_valid.
  task automatic txn(input int d, input logic we, input logic [8:0] addr, input logic [2:0] f3,
                     input logic [31:0] wd, output logic [31:0] rd, output logic er,
                     output int lat, output logic rdy_after);
    @(negedge CLK);
    req_we[d]     = we;
    req_addr[d]   = addr;
    req_funct3[d] = f3;
    req_wdata[d]  = wd;
    req_valid[d]  = 1'b1;
    rsp_ready[d]  = 1'b1;
    @(posedge CLK);
    #1;
    req_valid[d]  = 1'b0;
    req_we[d]     = 1'($urandom);
    req_addr[d]   = 9'($urandom);
    req_funct3[d] = 3'($urandom);
    req_wdata[d]  = $urandom;
    lat = 0;
    rd  = 'x;
    er  = 1'bx;
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK);
      if (rsp_valid[d]) begin
        lat = k;
        break;
      end
    end
    rd = rsp_rdata[d];
    er = rsp_err[d];
    @(posedge CLK);
    #1;
    rdy_after    = req_ready[d];
    rsp_ready[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic        rdy;
    logic        seen;
    logic [31:0] held;

    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
      req_funct3[d] = '0; req_wdata[d] = '0; rsp_ready[d] = 1'b0;
    end

    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("rst_rsp_err",   32'(rsp_err[0]),   32'd0);
    chk("rst_rsp_rdata", rsp_rdata[0],      32'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    chk("rst_req_ready", 32'(req_ready[0]), 32'd1);

    txn(0, 1'b1, 9'h010, 3'b010, 32'hDEADBEEF, rd, er, lat, rdy);
    chk("sw_err", 32'(er), 32'd0);
    chk("sw_rdata", rd, 32'd0);
    txn(0, 1'b0, 9'h010, 3'b010, 32'h0, rd, er, lat, rdy);
    chk("lw_rdata", rd, 32'hDEADBEEF);
    chk("lw_err", 32'(er), 32'd0);
    chk("lw_latency", 32'(lat), 32'd3);
    chk("lw_ready_after", 32'(rdy), 32'd1);

    txn(0, 1'b0, 9'h013, 3'b000, 32'h0, rd, er, lat, rdy);
    chk("lb_13", rd, 32'hFFFFFFDE);
    txn(0, 1'b0, 9'h013, 3'b100, 32'h0, rd, er, lat, rdy);
    chk("lbu_13", rd, 32'h000000DE);
    txn(0, 1'b0, 9'h012, 3'b001, 32'h0, rd, er, lat, rdy);
    chk("lh_12", rd, 32'hFFFFDEAD);
    txn(0, 1'b0, 9'h010, 3'b101, 32'h0, rd, er, lat, rdy);
    chk("lhu_10", rd, 32'h0000BEEF);

    txn(0, 1'b1, 9'h011, 3'b001, 32'h00001234, rd, er, lat, rdy);
    chk("sh_mis_err", 32'(er), 32'd1);
    chk("sh_mis_latency", 32'(lat), 32'd3);
    txn(0, 1'b0, 9'h010, 3'b010, 32'h0, rd, er, lat, rdy);
    chk("sh_mis_nowrite", rd, 32'hDEADBEEF);

    txn(0, 1'b0, 9'h012, 3'b010, 32'h0, rd, er, lat, rdy);
    chk("lw_mis_err", 32'(er), 32'd1);
    chk("lw_mis_rdata", rd, 32'd0);
    txn(0, 1'b0, 9'h010, 3'b011, 32'h0, rd, er, lat, rdy);
    chk("ld_f3_011_err", 32'(er), 32'd1);
    txn(0, 1'b1, 9'h010, 3'b100, 32'h11111111, rd, er, lat, rdy);
    chk("st_f3_100_err", 32'(er), 32'd1);
    txn(0, 1'b0, 9'h010, 3'b010, 32'h0, rd, er, lat, rdy);
    chk("st_f3_100_nowrite", rd, 32'hDEADBEEF);

    txn(0, 1'b1, 9'h1FC, 3'b010, 32'h01234567, rd, er, lat, rdy);
    chk("sw_top_err", 32'(er), 32'd0);
    txn(0, 1'b0, 9'h1FC, 3'b010, 32'h0, rd, er, lat, rdy);
    chk("lw_top", rd, 32'h01234567);
    txn(0, 1'b0, 9'h1FE, 3'b000, 32'h0, rd, er, lat, rdy);
    chk("lb_1fe", rd, 32'h00000023);
    txn(0, 1'b0, 9'h1FE, 3'b001, 32'h0, rd, er, lat, rdy);
    chk("lh_1fe", rd, 32'h00000123);

    // Back-pressure: response held for five cycles while new requests are offered and ignored.
    @(negedge CLK);
    req_we[0] = 1'b0; req_addr[0] = 9'h010; req_funct3[0] = 3'b010; req_valid[0] = 1'b1;
    rsp_ready[0] = 1'b0;
    @(posedge CLK);
    #1;
    req_valid[0] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (rsp_valid[0]) begin
        seen = 1'b1;
        break;
      end
    end
    chk("bp_valid_seen", 32'(seen), 32'd1);
    held = rsp_rdata[0];
    chk("bp_rdata", held, 32'hDEADBEEF);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_funct3[0] = 3'b010; req_wdata[0] = 32'h0;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      chk("bp_hold_valid", 32'(rsp_valid[0]), 32'd1);
      chk("bp_hold_rdata", rsp_rdata[0], 32'hDEADBEEF);
      chk("bp_hold_ready", 32'(req_ready[0]), 32'd0);
    end
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(posedge CLK);
    #1;
    chk("bp_ready_after", 32'(req_ready[0]), 32'd1);
    chk("bp_valid_after", 32'(rsp_valid[0]), 32'd0);
    rsp_ready[0] = 1'b0;
    txn(0, 1'b0, 9'h010, 3'b010, 32'h0, rd, er, lat, rdy);
    chk("bp_store_ignored", rd, 32'hDEADBEEF);

    // Reset during WAIT abandons SW 0x0 at 0x010.
    @(negedge CLK);
    req_we[0] = 1'b1; req_addr[0] = 9'h010; req_funct3[0] = 3'b010; req_wdata[0] = 32'h0;
    req_valid[0] = 1'b1; rsp_ready[0] = 1'b1;
    @(posedge CLK);
    #1;
    req_valid[0] = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      if (rsp_valid[0]) seen = 1'b1;
    end
    chk("rst_wait_no_rsp", 32'(seen), 32'd0);
    chk("rst_wait_ready", 32'(req_ready[0]), 32'd1);
    rsp_ready[0] = 1'b0;
    txn(0, 1'b0, 9'h010, 3'b010, 32'h0, rd, er, lat, rdy);
    chk("rst_wait_nowrite", rd, 32'hDEADBEEF);

    txn(0, 1'b1, 9'h011, 3'b000, 32'h00000080, rd, er, lat, rdy);
    txn(0, 1'b0, 9'h011, 3'b000, 32'h0, rd, er, lat, rdy);
    chk("lb_11_neg", rd, 32'hFFFFFF80);
    txn(0, 1'b0, 9'h010, 3'b010, 32'h0, rd, er, lat, rdy);
    chk("sb_11_merge", rd, 32'hDEAD80EF);

    // Zero wait states.
    txn(1, 1'b1, 9'h1FF, 3'b000, 32'h000000A5, rd, er, lat, rdy);
    chk("w0_sb_err", 32'(er), 32'd0);
    chk("w0_sb_latency", 32'(lat), 32'd1);
    txn(1, 1'b0, 9'h1FF, 3'b100, 32'h0, rd, er, lat, rdy);
    chk("w0_lbu_1ff", rd, 32'h000000A5);
    chk("w0_lbu_latency", 32'(lat), 32'd1);
    chk("w0_ready_after", 32'(rdy), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
